result_writer: RTL and testbench

RESULT_WRITER -- requirements
Module: result_writer

---
 rtl/result_writer_pkg.sv | 7 +
 rtl/result_fifo.sv | 49 ++++
 rtl/result_writer.sv | 122 ++++++++++++
 tb/tb_result_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_writer_pkg.sv
// Shared definitions for the result writer and the MAC stage feeding it.
package result_writer_pkg;
  // Width of one MAC result; the MAC stage sizes its output from this too.
  localparam int RESULT_W = 20;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO between the MAC stage and the result RAM.
// Pointers carry one wrap bit so full and empty can be told apart.
// Push while full is safe when a pop happens in the same cycle: the slot
// being written is the one whose data is being read out combinationally.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointer update; clr restarts the FIFO at job start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; data needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == CW'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/result_writer.sv
// Result writer: buffers MAC sums in a FIFO and writes them in order to the
// result RAM at BASE_ADDR onward, one job of NUM_RESULTS sums at a time.
// Optional feature macro RESULT_WRITER_MAX_EN adds running-maximum outputs
// (max_val / max_idx) tracked over the words written to RAM.
// A job whose results were dropped on overflow never reaches the full write
// count and stays in DRAIN until reset.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int NUM_RESULTS = 64,
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sum_valid,
  input  logic [RESULT_W-1:0] sum_in,
  output logic                stall,
  input  logic                ram_grant,
  output logic                ram_csn,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [RESULT_W-1:0] ram_wdata,
  output logic                busy,
  output logic                done,
  output logic                overflow
`ifdef RESULT_WRITER_MAX_EN
  ,
  output logic [RESULT_W-1:0] max_val,
  output logic [ADDR_W-1:0]   max_idx
`endif
);
  localparam int CNT_W = $clog2(NUM_RESULTS + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  logic [CNT_W-1:0]    acc_cnt, wr_cnt;
  logic                fifo_full, fifo_empty;
  logic [FC_W-1:0]     fifo_count;
  logic [RESULT_W-1:0] head;
  logic                active, job_clr, push_try, push, pop;

  assign active   = (state == RUN) || (state == DRAIN);
  assign job_clr  = (state == IDLE) && start;
  assign pop      = active && !fifo_empty && ram_grant;
  assign push_try = (state == RUN) && sum_valid;
  // A full FIFO still takes the sum if the head leaves this cycle
  assign push     = push_try && (!fifo_full || pop);

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RESULT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (job_clr),
    .push  (push),
    .pop   (pop),
    .wdata (sum_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Job FSM with accept/write counters and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) wr_cnt <= wr_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          acc_cnt  <= '0;
          wr_cnt   <= '0;
          overflow <= 1'b0;
        end
        RUN: if (push_try) begin
          acc_cnt <= acc_cnt + 1'b1;
          if (!push) overflow <= 1'b1;
          if (acc_cnt == CNT_W'(NUM_RESULTS - 1)) state <= DRAIN;
        end
        DRAIN: if (fifo_empty && (wr_cnt == CNT_W'(NUM_RESULTS))) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two entries of headroom cover the sum already in flight in the MAC
  assign stall     = (fifo_count >= FC_W'(FIFO_DEPTH - 2));
  assign ram_csn   = !pop;
  assign ram_wen   = !pop;
  assign ram_addr  = pop ? ADDR_W'(BASE_ADDR) + ADDR_W'(wr_cnt) : '0;
  assign ram_wdata = pop ? head : '0;
  assign busy      = active;
  assign done      = (state == DONE);

`ifdef RESULT_WRITER_MAX_EN
  // Running maximum over written words; strict compare keeps the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (job_clr) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (pop && (head > max_val)) begin
      max_val <= head;
      max_idx <= ram_addr;
    end
  end
`else
  // No maximum tracking in this build
`endif
endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer. Two instances share the stimulus:
// da runs 4-result jobs, db runs 6-result jobs; each test resets first.
module tb_result_writer;
  import result_writer_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                start, sum_valid, ram_grant;
  logic [RESULT_W-1:0] sum_in;

  logic                a_stall, a_csn, a_wen, a_busy, a_done, a_ovf;
  logic [7:0]          a_addr;
  logic [RESULT_W-1:0] a_wdata;
  logic                b_stall, b_csn, b_wen, b_busy, b_done, b_ovf;
  logic [7:0]          b_addr;
  logic [RESULT_W-1:0] b_wdata;
`ifdef RESULT_WRITER_MAX_EN
  logic [RESULT_W-1:0] a_max_val, b_max_val;
  logic [7:0]          a_max_idx, b_max_idx;
`endif

  int checks = 0;
  int failures = 0;
  logic [27:0] qa[$], qb[$];
  int a_done_n = 0, b_done_n = 0;

  always #5 clk = ~clk;

  result_writer #(.NUM_RESULTS(4), .ADDR_W(8), .BASE_ADDR(0), .FIFO_DEPTH(4)) da (
    .clk(clk), .rst(rst), .start(start), .sum_valid(sum_valid), .sum_in(sum_in),
    .stall(a_stall), .ram_grant(ram_grant), .ram_csn(a_csn), .ram_wen(a_wen),
    .ram_addr(a_addr), .ram_wdata(a_wdata), .busy(a_busy), .done(a_done),
    .overflow(a_ovf)
`ifdef RESULT_WRITER_MAX_EN
    , .max_val(a_max_val), .max_idx(a_max_idx)
`endif
  );

  result_writer #(.NUM_RESULTS(6), .ADDR_W(8), .BASE_ADDR(0), .FIFO_DEPTH(4)) db (
    .clk(clk), .rst(rst), .start(start), .sum_valid(sum_valid), .sum_in(sum_in),
    .stall(b_stall), .ram_grant(ram_grant), .ram_csn(b_csn), .ram_wen(b_wen),
    .ram_addr(b_addr), .ram_wdata(b_wdata), .busy(b_busy), .done(b_done),
    .overflow(b_ovf)
`ifdef RESULT_WRITER_MAX_EN
    , .max_val(b_max_val), .max_idx(b_max_idx)
`endif
  );

  // Record RAM writes and done pulses mid-cycle
  always @(negedge clk) begin
    if (!a_csn && !a_wen) qa.push_back({a_addr, a_wdata});
    if (!b_csn && !b_wen) qb.push_back({b_addr, b_wdata});
    if (a_done) a_done_n++;
    if (b_done) b_done_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; sum_valid = 1'b0; sum_in = '0; ram_grant = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [RESULT_W-1:0] v);
    sum_valid = 1'b1; sum_in = v;
    tick();
    sum_valid = 1'b0; sum_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; sum_valid = 1'b1; sum_in = 20'd99; ram_grant = 1'b1;
    repeat (2) tick();
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", a_done); end
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
    checks++; if ({a_csn, a_wen} !== 2'b11) begin failures++; $display("FAIL reset_ram_ctl got=%b exp=11", {a_csn, a_wen}); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", a_ovf); end
    checks++; if (a_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", a_addr); end
  endtask

  task automatic test_basic();
    int q0, d0;
    logic [27:0] exp;
    do_reset();
    q0 = qa.size(); d0 = a_done_n;
    ram_grant = 1'b1;
    start_job();
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", a_busy); end
    send(20'd10); send(20'd20); send(20'd30); send(20'd40);
    repeat (10) tick();
    checks++; if (qa.size() - q0 !== 4) begin failures++; $display("FAIL basic_nwrites got=%0d exp=4", qa.size() - q0); end
    for (int i = 0; i < 4; i++) begin
      exp = {8'(i), 20'((i + 1) * 10)};
      checks++;
      if (qa[q0 + i] !== exp) begin failures++; $display("FAIL basic_write%0d got=%h exp=%h", i, qa[q0 + i], exp); end
    end
    checks++; if (a_done_n - d0 !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", a_done_n - d0); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%b exp=0", a_ovf); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", a_busy); end
  endtask

  task automatic test_blocked();
    int q0;
    logic [27:0] exp;
    do_reset();
    q0 = qa.size();
    start_job();
    send(20'd100);
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL blocked_stall1 got=%b exp=0", a_stall); end
    send(20'd200);
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL blocked_stall2 got=%b exp=1", a_stall); end
    send(20'd300);
    repeat (4) tick();
    checks++; if (qa.size() - q0 !== 0) begin failures++; $display("FAIL blocked_nowrite got=%0d exp=0", qa.size() - q0); end
    ram_grant = 1'b1;
    repeat (6) tick();
    checks++; if (qa.size() - q0 !== 3) begin failures++; $display("FAIL blocked_nwrites got=%0d exp=3", qa.size() - q0); end
    for (int i = 0; i < 3; i++) begin
      exp = {8'(i), 20'((i + 1) * 100)};
      checks++;
      if (qa[q0 + i] !== exp) begin failures++; $display("FAIL blocked_write%0d got=%h exp=%h", i, qa[q0 + i], exp); end
    end
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL blocked_stall_drained got=%b exp=0", a_stall); end
  endtask

  task automatic test_overflow();
    int q0;
    logic [27:0] exp;
    do_reset();
    q0 = qb.size();
    start_job();
    send(20'd1); send(20'd2); send(20'd3); send(20'd4);
    checks++; if (b_ovf !== 1'b0) begin failures++; $display("FAIL ovf_after4 got=%b exp=0", b_ovf); end
    send(20'd5);
    checks++; if (b_ovf !== 1'b1) begin failures++; $display("FAIL ovf_after5 got=%b exp=1", b_ovf); end
    checks++; if (db.state !== RUN) begin failures++; $display("FAIL ovf_run_after5 got=%0d exp=%0d", db.state, RUN); end
    send(20'd6);
    checks++; if (db.state !== DRAIN) begin failures++; $display("FAIL ovf_drain got=%0d exp=%0d", db.state, DRAIN); end
    checks++; if (qb.size() - q0 !== 0) begin failures++; $display("FAIL ovf_nowrite got=%0d exp=0", qb.size() - q0); end
    ram_grant = 1'b1;
    repeat (8) tick();
    checks++; if (qb.size() - q0 !== 4) begin failures++; $display("FAIL ovf_nwrites got=%0d exp=4", qb.size() - q0); end
    for (int i = 0; i < 4; i++) begin
      exp = {8'(i), 20'(i + 1)};
      checks++;
      if (qb[q0 + i] !== exp) begin failures++; $display("FAIL ovf_write%0d got=%h exp=%h", i, qb[q0 + i], exp); end
    end
    checks++; if (b_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", b_ovf); end
  endtask

  task automatic test_full_pop();
    int q0, d0;
    logic [27:0] exp;
    do_reset();
    q0 = qb.size(); d0 = b_done_n;
    start_job();
    send(20'd11); send(20'd12); send(20'd13); send(20'd14);
    ram_grant = 1'b1;
    send(20'd15);
    checks++; if (b_ovf !== 1'b0) begin failures++; $display("FAIL fullpop_overflow got=%b exp=0", b_ovf); end
    repeat (6) tick();
    checks++; if (qb.size() - q0 !== 5) begin failures++; $display("FAIL fullpop_nwrites got=%0d exp=5", qb.size() - q0); end
    for (int i = 0; i < 5; i++) begin
      exp = {8'(i), 20'(11 + i)};
      checks++;
      if (qb[q0 + i] !== exp) begin failures++; $display("FAIL fullpop_write%0d got=%h exp=%h", i, qb[q0 + i], exp); end
    end
    send(20'd16);
    repeat (6) tick();
    exp = {8'd5, 20'd16};
    checks++; if (qb[q0 + 5] !== exp) begin failures++; $display("FAIL fullpop_last got=%h exp=%h", qb[q0 + 5], exp); end
    checks++; if (b_done_n - d0 !== 1) begin failures++; $display("FAIL fullpop_done got=%0d exp=1", b_done_n - d0); end
  endtask

  task automatic test_reset_mid();
    int q0, d0;
    logic [27:0] exp;
    do_reset();
    start_job();
    send(20'd7); send(20'd8);
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL rmid_stall_pre got=%b exp=1", a_stall); end
    rst = 1'b0; ram_grant = 1'b1;
    #2;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", a_busy); end
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL rmid_stall got=%b exp=0", a_stall); end
    checks++; if (a_csn !== 1'b1) begin failures++; $display("FAIL rmid_csn got=%b exp=1", a_csn); end
    q0 = qa.size(); d0 = a_done_n;
    tick(); tick();
    rst = 1'b1;
    repeat (5) tick();
    checks++; if (qa.size() - q0 !== 0) begin failures++; $display("FAIL rmid_nowrite got=%0d exp=0", qa.size() - q0); end
    checks++; if (a_done_n - d0 !== 0) begin failures++; $display("FAIL rmid_nodone got=%0d exp=0", a_done_n - d0); end
    start_job();
    send(20'd1); send(20'd2); send(20'd3); send(20'd4);
    repeat (10) tick();
    checks++; if (qa.size() - q0 !== 4) begin failures++; $display("FAIL rmid_clean_nwrites got=%0d exp=4", qa.size() - q0); end
    exp = {8'd0, 20'd1};
    checks++; if (qa[q0] !== exp) begin failures++; $display("FAIL rmid_clean_first got=%h exp=%h", qa[q0], exp); end
    checks++; if (a_done_n - d0 !== 1) begin failures++; $display("FAIL rmid_clean_done got=%0d exp=1", a_done_n - d0); end
  endtask

`ifdef RESULT_WRITER_MAX_EN
  task automatic test_max();
    do_reset();
    ram_grant = 1'b1;
    start_job();
    send(20'd5); send(20'd900); send(20'd900); send(20'd7);
    repeat (10) tick();
    checks++; if (a_max_val !== 20'd900) begin failures++; $display("FAIL max_val got=%0d exp=900", a_max_val); end
    checks++; if (a_max_idx !== 8'd1) begin failures++; $display("FAIL max_idx got=%0d exp=1", a_max_idx); end
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; sum_valid = 1'b0; sum_in = '0; ram_grant = 1'b0;
    test_reset();
    test_basic();
    test_blocked();
    test_overflow();
    test_full_pop();
    test_reset_mid();
`ifdef RESULT_WRITER_MAX_EN
    test_max();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
